icache: RTL

- Direct-mapped, one-word-per-line instruction cache between the fetch stage (iF) and mem_control.
- Serves hits with one-cycle registered latency, one per cycle.
- On a miss, issues a single word fetch to mem_control, fills the line, then returns the instruction.
- Honours branch_interception flush and the rdy pause.

---
 rtl/icache.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache between the fetch stage and mem_control.
// Hits respond one cycle after the request. A miss issues one word fetch, fills the line, then responds.
module icache #(
  parameter int INDEX_BITS = 7,
  parameter int ADDR_USED  = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        req_valid,
  input  logic [31:0] req_pc,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_pc,
  output logic [31:0] resp_inst,
  output logic        mc_req,
  output logic [31:0] mc_addr,
  input  logic        mc_valid,
  input  logic [31:0] mc_addr_back,
  input  logic [31:0] mc_inst
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_USED - INDEX_BITS - 2;

  typedef enum logic {IDLE, MISS} state_t;

  state_t             state_q, state_d;
  logic [31:0]        pend_pc_q, pend_pc_d;
  logic               resp_valid_q, resp_valid_d;
  logic [31:0]        resp_pc_q, resp_pc_d;
  logic [31:0]        resp_inst_q, resp_inst_d;
  logic               mc_req_q, mc_req_d;
  logic               busy_q, busy_d;
  logic [LINES-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q [LINES];
  logic [31:0]        data_q [LINES];

  logic [31:0]            req_word;
  logic [INDEX_BITS-1:0]  req_idx, pend_idx;
  logic [TAG_W-1:0]       req_tag, pend_tag;
  logic                   req_hit, pend_cacheable, fill_match, fill_we;

  // The top two used address bits select the I/O region, which is never cached.
  assign req_word       = req_pc & 32'hFFFF_FFFC;
  assign req_idx        = req_word[INDEX_BITS+1:2];
  assign req_tag        = req_word[ADDR_USED-1:INDEX_BITS+2];
  assign req_hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag)
                          && (req_word[ADDR_USED-1:ADDR_USED-2] != 2'b11);
  assign pend_idx       = pend_pc_q[INDEX_BITS+1:2];
  assign pend_tag       = pend_pc_q[ADDR_USED-1:INDEX_BITS+2];
  assign pend_cacheable = (pend_pc_q[ADDR_USED-1:ADDR_USED-2] != 2'b11);
  assign fill_match     = mc_valid && (mc_addr_back == pend_pc_q);

  always_comb begin
    state_d      = state_q;
    pend_pc_d    = pend_pc_q;
    resp_valid_d = resp_valid_q;
    resp_pc_d    = resp_pc_q;
    resp_inst_d  = resp_inst_q;
    mc_req_d     = mc_req_q;
    busy_d       = busy_q;
    valid_d      = valid_q;
    fill_we      = 1'b0;
    if (rdy) begin
      resp_valid_d = 1'b0;
      if (flush) begin
        state_d  = IDLE;
        mc_req_d = 1'b0;
        busy_d   = 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (req_valid) begin
              if (req_hit) begin
                resp_valid_d = 1'b1;
                resp_pc_d    = req_word;
                resp_inst_d  = data_q[req_idx];
              end else begin
                pend_pc_d = req_word;
                mc_req_d  = 1'b1;
                busy_d    = 1'b1;
                state_d   = MISS;
              end
            end
          end
          MISS: begin
            if (fill_match) begin
              fill_we      = pend_cacheable;
              resp_valid_d = 1'b1;
              resp_pc_d    = pend_pc_q;
              resp_inst_d  = mc_inst;
              mc_req_d     = 1'b0;
              busy_d       = 1'b0;
              state_d      = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
    if (fill_we) valid_d[pend_idx] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pend_pc_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= '0;
      resp_inst_q  <= '0;
      mc_req_q     <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      pend_pc_q    <= pend_pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      resp_inst_q  <= resp_inst_d;
      mc_req_q     <= mc_req_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
    end
  end

  // Tag and data storage needs no reset; the valid bits guard it.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[pend_idx]  <= pend_tag;
      data_q[pend_idx] <= mc_inst;
    end
  end

  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_pc    = resp_pc_q;
  assign resp_inst  = resp_inst_q;
  assign mc_req     = mc_req_q;
  assign mc_addr    = pend_pc_q;

endmodule
